// File: rtl/z80_io_ctrl_if.sv
// Z80 port bus and keyboard receiver signals for the I/O and interrupt controller.
interface z80_io_ctrl_if;
  logic [15:0] pin_pa;
  logic [7:0]  pin_po;
  logic        pin_pw;
  logic [7:0]  pin_pi;
  logic        pin_intr;
  logic [7:0]  kbd_data;
  logic        kbd_valid;

  modport master (output pin_pa, pin_po, pin_pw, kbd_data, kbd_valid,
                  input  pin_pi, pin_intr);
  modport slave  (input  pin_pa, pin_po, pin_pw, kbd_data, kbd_valid,
                  output pin_pi, pin_intr);
endinterface

// File: rtl/z80_io_ctrl.sv
// Port-mapped I/O and interrupt controller: scancode FIFO, periodic timer,
// masked level interrupt to the Z80 core.
module z80_io_ctrl #(
  parameter logic [7:0] BASE      = 8'h60,
  parameter int         DEPTH     = 8,
  parameter int         TIMER_DIV = 20000
) (
  input  logic         clk,
  input  logic         reset_n,
  z80_io_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMER_DIV);
  localparam logic [7:0]    A_STATUS = BASE;
  localparam logic [7:0]    A_DATA   = BASE + 8'd1;
  localparam logic [7:0]    A_MASK   = BASE + 8'd2;
  localparam logic [7:0]    A_ACK    = BASE + 8'd3;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMER_DIV - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [1:0]    pending, mask;
  logic          overflow;
  logic [TW-1:0] tmr;
  logic          intr_q;

  logic [7:0]    a;
  logic          empty, full, pop, push, drop, tick, ack, mask_wr;
  logic [1:0]    pend_set, pend_clr, pend_nx, mask_nx;
  logic          ovf_nx;

  // Upper address byte and unused data bits are decoded by nothing.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.pin_pa[15:8], bus.pin_po[6:2]};

  assign a       = bus.pin_pa[7:0];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = bus.pin_pw && (a == A_DATA) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = bus.kbd_valid && (!full || pop);
  assign drop    = bus.kbd_valid && full && !pop;
  assign tick    = (tmr == TMR_LAST);
  assign ack     = bus.pin_pw && (a == A_ACK);
  assign mask_wr = bus.pin_pw && (a == A_MASK);

  always_comb begin
    pend_set = {push, tick};
    pend_clr = ack ? bus.pin_po[1:0] : 2'b00;
    pend_nx  = (pending & ~pend_clr) | pend_set;
    mask_nx  = mask_wr ? bus.pin_po[1:0] : mask;
    ovf_nx   = drop | (overflow & ~(ack & bus.pin_po[7]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      mask     <= '0;
      overflow <= 1'b0;
      tmr      <= '0;
      intr_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(push) - CW'(pop);
      pending  <= pend_nx;
      mask     <= mask_nx;
      overflow <= ovf_nx;
      tmr      <= tick ? '0 : tmr + TW'(1);
      intr_q   <= |(pend_nx & mask_nx);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.kbd_data;
  end

  always_comb begin
    bus.pin_pi = 8'hFF;
    case (a)
      A_STATUS: bus.pin_pi = {overflow, 3'b000, pending[1], pending[0], full, !empty};
      A_DATA:   bus.pin_pi = empty ? 8'h00 : mem[rd_ptr];
      A_MASK:   bus.pin_pi = {6'b0, mask};
      A_ACK:    bus.pin_pi = 8'h00;
      default:  bus.pin_pi = 8'hFF;
    endcase
  end

  assign bus.pin_intr = intr_q;
endmodule

// File: tb/tb_z80_io_ctrl.sv
// Directed bench for z80_io_ctrl: queue-based model checked every cycle,
// plus literal checks and a second instance with a short timer period.
module tb_z80_io_ctrl;
  localparam logic [7:0] BASE  = 8'h60;
  localparam int         DEPTH = 8;
  localparam int         TDIV  = 20000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0, n_total = 0;
  bit   timer_done = 1'b0;

  always #5 clk = ~clk;

  z80_io_ctrl_if bus();
  z80_io_ctrl_if tbus();

  z80_io_ctrl #(.BASE(BASE), .DEPTH(DEPTH), .TIMER_DIV(TDIV)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  z80_io_ctrl #(.BASE(BASE), .DEPTH(DEPTH), .TIMER_DIV(10)) dut_t (
    .clk(clk), .reset_n(reset_n), .bus(tbus));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // ---------------- behavioural model of the main instance ----------------
  logic [7:0] q[$];
  bit [1:0]   m_pend, m_mask;
  bit         m_ovf, m_intr;
  int         m_tmr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete(); m_pend = '0; m_mask = '0; m_ovf = 0; m_intr = 0; m_tmr = 0;
    end else begin : upd
      bit [1:0] set, clr;
      bit ovf_set, ovf_clr;
      logic [7:0] ad;
      set = '0; clr = '0; ovf_set = 0; ovf_clr = 0;
      ad = bus.pin_pa[7:0];
      if (bus.pin_pw && ad == BASE + 8'd1 && q.size() > 0) void'(q.pop_front());
      if (bus.kbd_valid) begin
        if (q.size() < DEPTH) begin q.push_back(bus.kbd_data); set[1] = 1; end
        else ovf_set = 1;
      end
      if (m_tmr == TDIV - 1) begin m_tmr = 0; set[0] = 1; end
      else m_tmr++;
      if (bus.pin_pw && ad == BASE + 8'd3) begin
        clr = bus.pin_po[1:0]; ovf_clr = bus.pin_po[7];
      end
      if (bus.pin_pw && ad == BASE + 8'd2) m_mask = bus.pin_po[1:0];
      m_pend = (m_pend & ~clr) | set;
      m_ovf  = (m_ovf && !ovf_clr) || ovf_set;
      m_intr = |(m_pend & m_mask);
    end
  end

  function automatic logic [7:0] exp_pi(input logic [7:0] ad);
    if (ad == BASE)        return {m_ovf, 3'b000, m_pend[1], m_pend[0],
                                   q.size() == DEPTH, q.size() != 0};
    if (ad == BASE + 8'd1) return (q.size() != 0) ? q[0] : 8'h00;
    if (ad == BASE + 8'd2) return {6'b0, m_mask};
    if (ad == BASE + 8'd3) return 8'h00;
    return 8'hFF;
  endfunction

  always @(negedge clk) begin
    chk("model_pi", bus.pin_pi, exp_pi(bus.pin_pa[7:0]));
    chk("model_intr", {7'b0, bus.pin_intr}, {7'b0, m_intr});
  end

  // ---------------- main instance stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic wr(input logic [7:0] ad, input logic [7:0] d);
    bus.pin_pa = {8'h00, ad}; bus.pin_po = d; bus.pin_pw = 1; tick(); bus.pin_pw = 0;
  endtask
  task automatic key(input logic [7:0] d);
    bus.kbd_data = d; bus.kbd_valid = 1; tick(); bus.kbd_valid = 0;
  endtask
  task automatic rd(input string nm, input logic [15:0] ad, input logic [7:0] exp);
    bus.pin_pa = ad; #1; chk(nm, bus.pin_pi, exp); tick();
  endtask

  initial begin
    bus.pin_pa = 16'h0060; bus.pin_po = 0; bus.pin_pw = 0;
    bus.kbd_data = 0; bus.kbd_valid = 0;
    #12 chk("rst_status", bus.pin_pi, 8'h00);
    chk("rst_intr", {7'b0, bus.pin_intr}, 8'h00);
    #9 reset_n = 1;
    tick();
    // 1: idle reads
    rd("t1_status", 16'h0060, 8'h00);
    rd("t1_data", 16'h0061, 8'h00);
    rd("t1_other", 16'h0070, 8'hFF);
    rd("t1_hi_ignored", 16'hAB60, 8'h00);
    chk("t1_intr", {7'b0, bus.pin_intr}, 8'h00);
    // 2: two keys, unmask, drain, ack
    key(8'h1C); key(8'h32);
    chk("t2_intr_masked", {7'b0, bus.pin_intr}, 8'h00);
    wr(8'h62, 8'h02);
    chk("t2_intr_on", {7'b0, bus.pin_intr}, 8'h01);
    rd("t2_mask", 16'h0062, 8'h02);
    rd("t2_head0", 16'h0061, 8'h1C); wr(8'h61, 8'h00);
    rd("t2_head1", 16'h0061, 8'h32); wr(8'h61, 8'h00);
    rd("t2_status", 16'h0060, 8'h08);
    wr(8'h63, 8'h02);
    chk("t2_intr_off", {7'b0, bus.pin_intr}, 8'h00);
    wr(8'h61, 8'h00);
    rd("t2_empty_pop", 16'h0060, 8'h00);
    // 3: overflow; a full FIFO is also non-empty, so bit0 joins 8'h8A
    for (int i = 0; i < 9; i++) key(8'h10 + 8'(i));
    rd("t3_status", 16'h0060, 8'h8B);
    wr(8'h63, 8'h80);
    rd("t3_ovf_clr", 16'h0060, 8'h0B);
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("t3_drain%0d", i), 16'h0061, 8'h10 + 8'(i));
      wr(8'h61, 8'h00);
    end
    rd("t3_status_end", 16'h0060, 8'h08);
    wr(8'h63, 8'h02);
    // 4: pop and push together when full
    for (int i = 0; i < 8; i++) key(8'h20 + 8'(i));
    rd("t4_full", 16'h0060, 8'h0B);
    bus.pin_pa = 16'h0061; bus.pin_pw = 1; bus.kbd_data = 8'h5A; bus.kbd_valid = 1;
    tick(); bus.pin_pw = 0; bus.kbd_valid = 0;
    rd("t4_still_full", 16'h0060, 8'h0B);
    for (int i = 1; i < 8; i++) begin
      rd($sformatf("t4_drain%0d", i), 16'h0061, 8'h20 + 8'(i));
      wr(8'h61, 8'h00);
    end
    rd("t4_last", 16'h0061, 8'h5A);
    wr(8'h61, 8'h00);
    wr(8'h63, 8'h02);
    rd("t4_status_end", 16'h0060, 8'h00);
    // 6: async reset with contents and interrupt live
    key(8'hA1); key(8'hA2); key(8'hA3);
    rd("t6_status", 16'h0060, 8'h09);
    chk("t6_intr_pre", {7'b0, bus.pin_intr}, 8'h01);
    for (int i = 0; i < 200 && !timer_done; i++) tick();
    chk("timer_done", {7'b0, timer_done}, 8'h01);
    bus.pin_pa = 16'h0060;
    reset_n = 0; #1;
    chk("t6_intr_async", {7'b0, bus.pin_intr}, 8'h00);
    chk("t6_status_async", bus.pin_pi, 8'h00);
    tick(); reset_n = 1;
    rd("t6_data_after", 16'h0061, 8'h00);
    rd("t6_mask_after", 16'h0062, 8'h00);
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // ---------------- 5: short-period timer instance ----------------
  initial begin
    tbus.pin_pa = 16'h0062; tbus.pin_po = 8'h01; tbus.pin_pw = 1;
    tbus.kbd_data = 0; tbus.kbd_valid = 0;
    @(posedge reset_n);
    @(posedge clk); #1 tbus.pin_pw = 0; tbus.pin_pa = 16'h0060;     // edge 1
    repeat (8) @(posedge clk);                                       // edges 2..9
    @(negedge clk);
    chk("t5_pre_status", tbus.pin_pi, 8'h00);
    chk("t5_pre_intr", {7'b0, tbus.pin_intr}, 8'h00);
    @(posedge clk);                                                  // edge 10: wrap
    @(negedge clk);
    chk("t5_wrap_status", tbus.pin_pi, 8'h04);
    chk("t5_wrap_intr", {7'b0, tbus.pin_intr}, 8'h01);
    repeat (9) @(posedge clk);                                       // edges 11..19
    #1 tbus.pin_pa = 16'h0063; tbus.pin_po = 8'h01; tbus.pin_pw = 1;
    @(posedge clk);                                                  // edge 20: wrap + ack
    #1 tbus.pin_pw = 0; tbus.pin_pa = 16'h0060;
    @(negedge clk);
    chk("t5_collide_status", tbus.pin_pi, 8'h04);
    chk("t5_collide_intr", {7'b0, tbus.pin_intr}, 8'h01);
    tbus.pin_pa = 16'h0063; tbus.pin_pw = 1;
    @(posedge clk);                                                  // edge 21: plain ack
    #1 tbus.pin_pw = 0; tbus.pin_pa = 16'h0060;
    @(negedge clk);
    chk("t5_ack_status", tbus.pin_pi, 8'h00);
    chk("t5_ack_intr", {7'b0, tbus.pin_intr}, 8'h00);
    timer_done = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout want finish");
    $fatal(1);
  end
endmodule
